// File: rtl/set_assoc_cache.sv
// N-way set-associative read-only cache with tree PLRU replacement, a registered
// miss/refill sequencer, whole-cache flush (deferred while busy) and saturating hit/miss counters.
//
// state  | meaning
// IDLE   | serve hits combinationally, apply flushes, launch refill on a miss
// REFILL | hold mem_read_en_o until the line returns, then install it
// RESP   | return the requested word from the just-installed line
module set_assoc_cache #(
   parameter int unsigned NrWays         = 4,
   parameter int unsigned NrLines        = 64,
   parameter int unsigned NrWordsPerLine = 4,
   parameter int unsigned CntWidth       = 32
) (
   input  logic                             clk_i,
   input  logic                             rstn_i,
   input  logic [31:0]                      addr_i,
   input  logic                             read_en_i,
   output logic                             read_valid_o,
   output logic [31:0]                      read_word_o,
   input  logic                             flush_i,
   output logic [31:0]                      mem_addr_o,
   output logic                             mem_read_en_o,
   input  logic                             mem_read_valid_i,
   input  logic [32*NrWordsPerLine-1:0]     mem_read_data_i,
   output logic [CntWidth-1:0]              hit_count_o,
   output logic [CntWidth-1:0]              miss_count_o
);

   localparam int unsigned WordBits       = $clog2(NrWordsPerLine);
   localparam int unsigned ByteOffsetBits = WordBits + 2;
   localparam int unsigned IndexBits      = $clog2(NrLines);
   localparam int unsigned TagBits        = 32 - IndexBits - ByteOffsetBits;
   localparam int unsigned TreeLevels     = $clog2(NrWays);
   localparam int unsigned WayBits        = (NrWays > 1) ? $clog2(NrWays) : 1;
   localparam int unsigned PlruBits       = (NrWays > 1) ? NrWays - 1 : 1;

   typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP} state_e;
   typedef logic [NrWordsPerLine-1:0][31:0] line_t;

   state_e                 state_q, state_d;
   logic [NrWays-1:0]      valid_q [NrLines];
   logic [NrWays-1:0]      valid_d [NrLines];
   logic [PlruBits-1:0]    plru_q  [NrLines];
   logic [PlruBits-1:0]    plru_d  [NrLines];
   logic                   flush_pend_q, flush_pend_d;
   logic [31:0]            mem_addr_q, mem_addr_d;
   logic                   mem_read_en_q, mem_read_en_d;
   logic [WayBits-1:0]     victim_q, victim_d;
   logic [CntWidth-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CntWidth-1:0]    miss_cnt_q, miss_cnt_d;

   // Tag/data storage is never reset; valid bits gate every use.
   logic [TagBits-1:0]     tag_mem  [NrLines][NrWays];
   line_t                  data_mem [NrLines][NrWays];

   logic [TagBits-1:0]     req_tag;
   logic [IndexBits-1:0]   req_index;
   logic [WordBits-1:0]    req_word;
   logic [TagBits-1:0]     refill_tag;
   logic [IndexBits-1:0]   refill_index;
   logic [NrWays-1:0]      hit_vec;
   logic                   hit;
   logic [WayBits-1:0]     hit_way;
   logic                   any_invalid;
   logic [WayBits-1:0]     first_invalid;
   logic                   refill_we;
   line_t                  line_sel;
   line_t                  refill_line;
   logic                   unused_addr_bits;

   assign req_tag          = addr_i[31 -: TagBits];
   assign req_index        = addr_i[ByteOffsetBits +: IndexBits];
   assign req_word         = addr_i[2 +: WordBits];
   assign unused_addr_bits = ^addr_i[1:0];

   // The refill target comes from the latched line address, so a dropped
   // request cannot redirect an in-flight install.
   assign refill_tag   = mem_addr_q[31 -: TagBits];
   assign refill_index = mem_addr_q[ByteOffsetBits +: IndexBits];
   assign refill_line  = mem_read_data_i;

   function automatic logic [WayBits-1:0] plru_victim(input logic [PlruBits-1:0] bits);
      logic [WayBits-1:0] way;
      int unsigned        node;
      logic               b;
      way  = '0;
      node = 0;
      for (int l = 0; l < int'(TreeLevels); l++) begin
         b    = bits[node];
         way  = (way << 1) | WayBits'(b);
         node = 2 * node + 1 + 32'(b);
      end
      return way;
   endfunction

   // Walk root to leaf, pointing each bit on the path away from the accessed way.
   function automatic logic [PlruBits-1:0] plru_update(input logic [PlruBits-1:0] bits,
                                                       input logic [WayBits-1:0]  way);
      logic [PlruBits-1:0] nb;
      logic [WayBits-1:0]  tmp;
      int unsigned         node;
      logic                d;
      nb   = bits;
      node = 0;
      for (int l = 0; l < int'(TreeLevels); l++) begin
         tmp      = way >> (int'(TreeLevels) - 1 - l);
         d        = tmp[0];
         nb[node] = ~d;
         node     = 2 * node + 1 + 32'(d);
      end
      return nb;
   endfunction

   always_comb begin
      hit_vec       = '0;
      hit_way       = '0;
      any_invalid   = 1'b0;
      first_invalid = '0;
      for (int w = 0; w < int'(NrWays); w++) begin
         hit_vec[w] = valid_q[req_index][w] && (tag_mem[req_index][w] == req_tag);
         if (hit_vec[w]) hit_way = WayBits'(w);
      end
      for (int w = int'(NrWays) - 1; w >= 0; w--) begin
         if (!valid_q[req_index][w]) begin
            any_invalid   = 1'b1;
            first_invalid = WayBits'(w);
         end
      end
      hit = |hit_vec;
   end

   always_comb begin
      state_d       = state_q;
      valid_d       = valid_q;
      plru_d        = plru_q;
      flush_pend_d  = flush_pend_q;
      mem_addr_d    = mem_addr_q;
      mem_read_en_d = mem_read_en_q;
      victim_d      = victim_q;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      refill_we     = 1'b0;
      read_valid_o  = 1'b0;
      line_sel      = data_mem[req_index][hit_way];

      unique case (state_q)
         S_IDLE: begin
            if (flush_i || flush_pend_q) begin
               for (int s = 0; s < int'(NrLines); s++) begin
                  valid_d[s] = '0;
                  plru_d[s]  = '0;
               end
               flush_pend_d = 1'b0;
            end else if (read_en_i) begin
               if (hit) begin
                  read_valid_o       = 1'b1;
                  plru_d[req_index]  = plru_update(plru_q[req_index], hit_way);
                  if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CntWidth'(1);
               end else begin
                  mem_addr_d    = {req_tag, req_index, {ByteOffsetBits{1'b0}}};
                  victim_d      = any_invalid ? first_invalid : plru_victim(plru_q[req_index]);
                  mem_read_en_d = 1'b1;
                  state_d       = S_REFILL;
                  if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CntWidth'(1);
               end
            end
         end
         S_REFILL: begin
            if (flush_i) flush_pend_d = 1'b1;
            if (mem_read_valid_i) begin
               refill_we                        = 1'b1;
               valid_d[refill_index][victim_q]  = 1'b1;
               plru_d[refill_index]             = plru_update(plru_q[refill_index], victim_q);
               mem_read_en_d                    = 1'b0;
               state_d                          = S_RESP;
            end
         end
         S_RESP: begin
            if (flush_i) flush_pend_d = 1'b1;
            read_valid_o = read_en_i;
            line_sel     = data_mem[refill_index][victim_q];
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign read_word_o   = line_sel[req_word];
   assign mem_addr_o    = mem_addr_q;
   assign mem_read_en_o = mem_read_en_q;
   assign hit_count_o   = hit_cnt_q;
   assign miss_count_o  = miss_cnt_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q       <= S_IDLE;
         flush_pend_q  <= 1'b0;
         mem_addr_q    <= '0;
         mem_read_en_q <= 1'b0;
         victim_q      <= '0;
         hit_cnt_q     <= '0;
         miss_cnt_q    <= '0;
         for (int s = 0; s < int'(NrLines); s++) begin
            valid_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q       <= state_d;
         flush_pend_q  <= flush_pend_d;
         mem_addr_q    <= mem_addr_d;
         mem_read_en_q <= mem_read_en_d;
         victim_q      <= victim_d;
         hit_cnt_q     <= hit_cnt_d;
         miss_cnt_q    <= miss_cnt_d;
         valid_q       <= valid_d;
         plru_q        <= plru_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (refill_we) begin
         data_mem[refill_index][victim_q] <= refill_line;
         tag_mem[refill_index][victim_q]  <= refill_tag;
      end
   end

endmodule
